// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 mux arbiter with a registered valid/ready output stage.
// Define ARB_BURST_EN to lock arbitration to one requester until req_last.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_vld,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_rdy,
  output logic                 out_vld,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_rdy
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_nxt;
  logic          ptr_upd;
  logic [N-1:0]  elig;
  logic [SW-1:0] win;
  logic          found;
  logic          load_en;
  logic          xfer;
  logic [W-1:0]  win_data;

`ifdef ARB_BURST_EN
  // state | meaning
  // IDLE  | per-beat round robin among all valid requesters
  // LOCK  | mid-burst; only owner_q may be granted until its req_last beat
  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;

  assign elig    = (state_q == LOCK) ? (req_vld & (N'(1) << owner_q)) : req_vld;
  assign ptr_upd = xfer && req_last[win];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (xfer && !req_last[win]) begin
          state_d = LOCK;
          owner_d = win;
        end
      end
      LOCK: begin
        if (xfer && req_last[win]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign elig        = req_vld;
  assign ptr_upd     = xfer;
`endif

  // First eligible requester at or above ptr_q, wrapping N-1 -> 0.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  assign load_en  = !out_vld || out_rdy;
  assign xfer     = rst_n && load_en && found;
  assign req_rdy  = xfer ? (N'(1) << win) : '0;
  assign win_data = req_data[win*W +: W];
  assign ptr_nxt  = (win == SW'(N - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
    end else if (load_en) begin
      out_vld <= xfer;
      if (xfer) begin
        out_data <= win_data;
        out_src  <= win;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else if (ptr_upd) ptr_q <= ptr_nxt;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter (N=4, W=8).
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_rdy;
  logic        out_vld;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_rdy;

  int n_total = 0;
  int n_pass  = 0;

  rr_mux_arbiter #(.N(4), .W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_src  (out_src),
    .out_rdy  (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, check the combinational grant, then the registered output.
  task automatic apply(input string tag, input logic [3:0] vld, input logic [3:0] last,
                       input logic [31:0] data, input logic ordy, input logic [3:0] exp_rdy,
                       input logic exp_ov, input logic [7:0] exp_od, input logic [1:0] exp_os);
    req_vld  = vld;
    req_last = last;
    req_data = data;
    out_rdy  = ordy;
    #1;
    chk({tag, " req_rdy"}, 32'(req_rdy), 32'(exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_vld"}, 32'(out_vld), 32'(exp_ov));
    chk({tag, " out_data"}, 32'(out_data), 32'(exp_od));
    chk({tag, " out_src"}, 32'(out_src), 32'(exp_os));
  endtask

  localparam logic [31:0] D0 = 32'h1312_1110;
  localparam logic [31:0] DA = 32'h1312_11A5;

  initial begin
    // round robin 0,1,2,3,0
    vecs[0]  = '{4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[1]  = '{4'b1111, D0, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[2]  = '{4'b1111, D0, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[3]  = '{4'b1111, D0, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[4]  = '{4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    // skip and wrap from ptr=1 with 1001
    vecs[5]  = '{4'b1001, D0, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[6]  = '{4'b1001, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[7]  = '{4'b1001, D0, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    // backpressure holding A5
    vecs[8]  = '{4'b0001, DA, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0};
    vecs[9]  = '{4'b1111, DA, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    vecs[10] = '{4'b1111, DA, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    vecs[11] = '{4'b1111, DA, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    vecs[12] = '{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // idle: output empties, data/src hold
    vecs[13] = '{4'b0000, D0, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[14] = '{4'b0000, D0, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    // valid dropped during a stall leaves ptr untouched
    vecs[15] = '{4'b0100, D0, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[16] = '{4'b0011, D0, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    vecs[17] = '{4'b0000, D0, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    vecs[18] = '{4'b0011, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};

    rst_n    = 1'b0;
    req_vld  = 4'b1111;
    req_last = 4'b1111;
    req_data = D0;
    out_rdy  = 1'b1;
    #3;
    chk("reset out_vld", 32'(out_vld), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_src", 32'(out_src), 32'd0);
    chk("reset req_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++)
      apply($sformatf("vec%0d", i), vecs[i].vld, 4'b1111, vecs[i].data, vecs[i].ordy,
            vecs[i].rdy, vecs[i].ov, vecs[i].od, vecs[i].os);

    // reset during a stall, with ptr=1
    req_vld = 4'b1111;
    out_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_vld", 32'(out_vld), 32'd0);
    chk("midrst out_data", 32'(out_data), 32'd0);
    chk("midrst out_src", 32'(out_src), 32'd0);
    chk("midrst req_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply("post_rst", 4'b1111, 4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);

`ifdef ARB_BURST_EN
    // burst from requester 2 with requester 0 competing; ptr=1 here
    apply("burst1", 4'b0101, 4'b0000, D0, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    apply("burst2", 4'b0101, 4'b0000, D0, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    apply("burst_gap", 4'b0001, 4'b0000, D0, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2);
    apply("burst3", 4'b0101, 4'b0100, D0, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    apply("after_burst", 4'b0101, 4'b1111, D0, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter N, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter W, default 8, SHALL set the data width per requester.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_vld  input  N  SHALL carry the per-requester valid; bit i belongs to requester i.
REQ-006 req_data  input  N*W  SHALL carry the per-requester data; slice [i*W +: W] belongs to requester i.
REQ-007 req_last  input  N  SHALL mark the last beat of a burst per requester; it is used only with ARB_BURST_EN.
REQ-008 req_rdy  output  N  SHALL be the per-requester ready, one-hot or zero.
REQ-009 out_vld  output  1  SHALL indicate that the shared output holds valid data.
REQ-010 out_data  output  W  SHALL carry the shared output data.
REQ-011 out_src  output  $clog2(N)  SHALL carry the index of the requester that supplied out_data.
REQ-012 out_rdy  input  1  SHALL be the downstream ready.

Function
REQ-013 The block SHALL select one requester's data onto a single registered output with valid/ready handshakes on both sides.
REQ-014 load_en SHALL equal (!out_vld || out_rdy); when high, the output register SHALL accept a new beat or go empty in the same cycle.
REQ-015 Winner: the first i with req_vld[i]=1, searching upward from ptr and wrapping N-1 -> 0.
REQ-016 req_rdy[winner] SHALL be asserted combinationally when load_en=1; all other bits SHALL be 0.
REQ-017 A transfer occurs when req_vld[i] && req_rdy[i]. On a transfer the block SHALL register out_data<=req_data[i], out_src<=i and out_vld<=1 at the next edge, so latency is 1 cycle.
REQ-018 When load_en=1 and no requester is valid, out_vld SHALL go 0 at the next edge; out_data and out_src SHALL hold their values.
REQ-019 When out_vld=1 and out_rdy=0, out_data and out_src SHALL stay stable, and req_rdy SHALL be all zero.
REQ-020 When out_vld=1 and out_rdy=1 with a new transfer in the same cycle, the output SHALL pass data back-to-back with no bubble.
REQ-021 ptr SHALL update to (i+1) mod N on every transfer from requester i and hold otherwise; wrap-around from N-1 SHALL give 0.
REQ-022 req_vld dropping without a transfer SHALL cause no state change.

Reset
REQ-023 When rst_n=0, asynchronously: out_vld=0, out_data=0, out_src=0, ptr=0, state=IDLE.
REQ-024 While rst_n=0, req_rdy SHALL be 0.
REQ-025 Reset asserted mid-burst or mid-stall SHALL drop the pending beat and release the lock.
REQ-026 After rst_n deasserts, the first arbitration SHALL start from requester 0.

Configuration
REQ-027 Macro ARB_BURST_EN SHALL enable burst locking.
REQ-028 With ARB_BURST_EN defined, the FSM SHALL have two states, IDLE and LOCK, plus an owner register of $clog2(N) bits.
- IDLE -> LOCK on a transfer with req_last[i]=0; owner<=i.
- LOCK: only the owner is eligible. If the owner's req_vld=0, no grant is given and other requesters wait.
- LOCK -> IDLE on an owner transfer with req_last=1.
- ptr SHALL update only when leaving LOCK, or on a single-beat transfer (req_last=1 in IDLE).
REQ-029 Without ARB_BURST_EN, req_last SHALL be ignored, there SHALL be no FSM or owner register, and arbitration is per beat (REQ-015..021).

Verification
REQ-030 Reset check: assert rst_n=0 mid-traffic -> out_vld=0, out_data=0, out_src=0 immediately; after release with all requesters valid, the first out_src=0.
REQ-031 Round robin: N=4, req_vld=4'b1111 held, out_rdy=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, with one req_rdy bit high per cycle.
REQ-032 Skip and wrap: req_vld=4'b1001, ptr=1 -> grant 3, then grant 0, then grant 3.
REQ-033 Backpressure: out_rdy=0 for 3 cycles with out_vld=1, out_data=8'hA5 -> out_data stable at A5, req_rdy=0; after out_rdy=1, the next beat appears the following cycle.
REQ-034 Idle: all req_vld=0, out_rdy=1 -> out_vld=0 one cycle after the last transfer, and out_data holds its last value.
REQ-035 Burst (with ARB_BURST_EN): requester 2 sends 3 beats with req_last=0,0,1 while requester 0 is valid -> out_src=2,2,2, then 0; if requester 2 drops req_vld mid-burst, no grant is given.
